pic_in_port: RTL and testbench

//   Input-side counterpart of the core's out_port: samples 8 external pins into the core's data space.

---
 rtl/pic_pkg.sv | 13 +
 rtl/pic_sync_filter.sv | 76 +++++++
 rtl/pic_in_port.sv | 64 ++++++
 tb/tb_pic_in_port.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared constants and types for the PIC-style peripheral blocks.
// File addresses the input ports decode, plus the pin filter state type.
package pic_pkg;

  localparam logic [6:0] PORTA_ADDR = 7'h06;
  localparam logic [6:0] PORTB_ADDR = 7'h07;

  typedef enum logic {
    F_IDLE = 1'b0,
    F_QUAL = 1'b1
  } filt_state_t;

endpackage

// File: rtl/pic_sync_filter.sv
// Synchroniser plus glitch filter for asynchronous input pins.
// A new value is accepted only after it has been stable for FILTER_CYCLES clocks.
module pic_sync_filter
  import pic_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_pin,
  output logic [WIDTH-1:0] o_filtered
);

  localparam int CW = $clog2(FILTER_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]                  w_s;
  logic [WIDTH-1:0]                  r_cand;
  logic [WIDTH-1:0]                  r_filtered;
  logic [CW-1:0]                     r_cnt;
  filt_state_t                       r_state;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // A return to the accepted value mid-qualification is a glitch, so it wins over a restart.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= F_IDLE;
      r_cand     <= '0;
      r_cnt      <= '0;
      r_filtered <= '0;
    end else begin
      case (r_state)
        F_IDLE: begin
          if (w_s != r_filtered) begin
            if (FILTER_CYCLES == 1) begin
              r_filtered <= w_s;
            end else begin
              r_cand  <= w_s;
              r_cnt   <= CW'(1);
              r_state <= F_QUAL;
            end
          end
        end
        F_QUAL: begin
          if (w_s == r_filtered) begin
            r_state <= F_IDLE;
          end else if (w_s != r_cand) begin
            r_cand <= w_s;
            r_cnt  <= CW'(1);
          end else if (r_cnt == CNT_LAST) begin
            r_filtered <= r_cand;
            r_state    <= F_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= F_IDLE;
      endcase
    end
  end

  assign o_filtered = r_filtered;

endmodule

// File: rtl/pic_in_port.sv
// Input port for the core's data space: filtered pins, read decode,
// last-read snapshot and a sticky interrupt-on-change flag.
module pic_in_port
  import pic_pkg::*;
#(
  parameter int         WIDTH         = 8,
  parameter int         SYNC_STAGES   = 2,
  parameter int         FILTER_CYCLES = 4,
  parameter logic [6:0] PORT_ADDR     = PORTA_ADDR
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_pin_in,
  input  logic [6:0]       i_address,
  input  logic             i_rd_en,
  input  logic             i_clr_flag,
  input  logic             i_irq_en,
  output logic [WIDTH-1:0] o_data_out,
  output logic             o_data_oe,
  output logic [WIDTH-1:0] o_filtered,
  output logic             o_change_flag,
  output logic             o_irq
);

  logic [WIDTH-1:0] w_filtered;
  logic             w_rd_hit;
  logic             w_mismatch;
  logic [WIDTH-1:0] r_snapshot;
  logic             r_change_flag;

  pic_sync_filter #(
    .WIDTH         (WIDTH),
    .SYNC_STAGES   (SYNC_STAGES),
    .FILTER_CYCLES (FILTER_CYCLES)
  ) u_sync_filter (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_pin      (i_pin_in),
    .o_filtered (w_filtered)
  );

  assign w_rd_hit   = i_rd_en && (i_address == PORT_ADDR);
  assign w_mismatch = (w_filtered != r_snapshot);

  // A persisting mismatch re-sets the flag on the same edge a clear arrives.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_snapshot    <= '0;
      r_change_flag <= 1'b0;
    end else begin
      if (w_rd_hit) begin
        r_snapshot <= w_filtered;
      end
      r_change_flag <= (r_change_flag & ~i_clr_flag) | w_mismatch;
    end
  end

  assign o_data_oe     = w_rd_hit;
  assign o_data_out    = w_rd_hit ? w_filtered : '0;
  assign o_filtered    = w_filtered;
  assign o_change_flag = r_change_flag;
  assign o_irq         = r_change_flag & i_irq_en;

endmodule

// File: tb/tb_pic_in_port.sv
// Randomised and directed bench for pic_in_port against a run-length
// model of the pin filter and a simple snapshot/flag model.
module tb_pic_in_port;

  localparam int         WIDTH  = 8;
  localparam int         SYNC   = 2;
  localparam int         FILT   = 4;
  localparam logic [6:0] PORT   = 7'h06;

  logic             clk = 1'b0;
  logic             rstN;
  logic [WIDTH-1:0] pinIn;
  logic [6:0]       address;
  logic             rdEn;
  logic             clrFlag;
  logic             irqEnable;
  logic [WIDTH-1:0] dataOut;
  logic             dataOe;
  logic [WIDTH-1:0] filtered;
  logic             changeFlag;
  logic             irq;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] pinPipe[$];
  logic [WIDTH-1:0] filtM;
  logic [WIDTH-1:0] snapM;
  logic [WIDTH-1:0] runVal;
  int               runLen;
  logic             flagM;

  pic_in_port #(
    .WIDTH         (WIDTH),
    .SYNC_STAGES   (SYNC),
    .FILTER_CYCLES (FILT),
    .PORT_ADDR     (PORT)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rstN),
    .i_pin_in      (pinIn),
    .i_address     (address),
    .i_rd_en       (rdEn),
    .i_clr_flag    (clrFlag),
    .i_irq_en      (irqEnable),
    .o_data_out    (dataOut),
    .o_data_oe     (dataOe),
    .o_filtered    (filtered),
    .o_change_flag (changeFlag),
    .o_irq         (irq)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    pinPipe.delete();
    for (int i = 0; i < SYNC; i++) pinPipe.push_back('0);
    filtM  = '0;
    snapM  = '0;
    flagM  = 1'b0;
    runVal = '0;
    runLen = 0;
  endtask

  // The filter accepts a value once the synchronised pins have shown it for FILT consecutive edges.
  task automatic modelStep(input logic [WIDTH-1:0] pin, input logic [6:0] addr, input logic rd, input logic clr);
    logic [WIDTH-1:0] s;
    s = pinPipe.pop_front();
    pinPipe.push_back(pin);
    flagM = (flagM & ~clr) | (filtM != snapM);
    if (rd && addr == PORT) snapM = filtM;
    if (s == runVal) runLen++;
    else begin
      runVal = s;
      runLen = 1;
    end
    if (s != filtM && runLen >= FILT) filtM = s;
  endtask

  task automatic compareAll();
    logic expOe;
    expOe = rdEn && (address == PORT);
    checkOutput("filtered", filtered, filtM);
    checkOutput("change_flag", changeFlag, flagM);
    checkOutput("irq", irq, flagM & irqEnable);
    checkOutput("data_oe", dataOe, expOe);
    checkOutput("data_out", dataOut, expOe ? filtM : '0);
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] pin, input logic [6:0] addr,
                               input logic rd, input logic clr, input logic irqE);
    @(negedge clk);
    pinIn     = pin;
    address   = addr;
    rdEn      = rd;
    clrFlag   = clr;
    irqEnable = irqE;
    @(posedge clk);
    if (rstN) modelStep(pin, addr, rd, clr);
    else modelReset();
    #1;
    compareAll();
  endtask

  task automatic holdPin(input logic [WIDTH-1:0] pin, input int n);
    for (int i = 0; i < n; i++) applyStimulus(pin, 7'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic readAndClear(input logic [WIDTH-1:0] pin);
    applyStimulus(pin, PORT, 1'b1, 1'b0, 1'b0);
    applyStimulus(pin, 7'h00, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [WIDTH-1:0] rPin;
    int               hold;
    logic             rRd;
    logic [6:0]       rAddr;

    rstN = 1'b0; pinIn = 8'hFF; address = '0; rdEn = 1'b0; clrFlag = 1'b0; irqEnable = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_filtered", filtered, 8'h00);
    checkOutput("rst_flag", changeFlag, 1'b0);
    checkOutput("rst_oe", dataOe, 1'b0);
    #1 rstN = 1'b1;

    for (int i = 1; i <= 6; i++) begin
      applyStimulus(8'hFF, 7'h00, 1'b0, 1'b0, 1'b0);
      checkOutput("rst_latency", filtered, (i == 6) ? 8'hFF : 8'h00);
    end
    applyStimulus(8'hFF, 7'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_flag_set", changeFlag, 1'b1);

    holdPin(8'h00, 8);
    readAndClear(8'h00);
    holdPin(8'h00, 2);
    checkOutput("quiet_flag", changeFlag, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(8'hA5, 7'h00, 1'b0, 1'b0, 1'b1);
      checkOutput("edge_latency", filtered, (i == 6) ? 8'hA5 : 8'h00);
    end
    applyStimulus(8'hA5, 7'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("edge_irq_on", irq, 1'b1);
    applyStimulus(8'hA5, 7'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("edge_irq_off", irq, 1'b0);

    holdPin(8'h00, 8);
    readAndClear(8'h00);
    holdPin(8'h01, 3);
    holdPin(8'h00, 8);
    checkOutput("glitch_filtered", filtered, 8'h00);
    checkOutput("glitch_flag", changeFlag, 1'b0);
    holdPin(8'h01, 2);
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(8'h02, 7'h00, 1'b0, 1'b0, 1'b0);
      checkOutput("restart_latency", filtered, (i == 6) ? 8'h02 : 8'h00);
    end

    holdPin(8'h3C, 8);
    checkOutput("rd_flag_before", changeFlag, 1'b1);
    applyStimulus(8'h3C, PORT, 1'b1, 1'b0, 1'b0);
    checkOutput("rd_oe", dataOe, 1'b1);
    checkOutput("rd_data", dataOut, 8'h3C);
    applyStimulus(8'h3C, 7'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("rd_clear", changeFlag, 1'b0);
    applyStimulus(8'h3C, 7'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("rd_stays_clear", changeFlag, 1'b0);
    applyStimulus(8'h3C, 7'h07, 1'b1, 1'b0, 1'b0);
    checkOutput("other_oe", dataOe, 1'b0);
    checkOutput("other_data", dataOut, 8'h00);

    holdPin(8'h55, 8);
    applyStimulus(8'h55, PORT, 1'b1, 1'b1, 1'b0);
    checkOutput("simul_flag_held", changeFlag, 1'b1);
    applyStimulus(8'h55, 7'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("simul_flag_clear", changeFlag, 1'b0);

    holdPin(8'hAA, 3);
    @(negedge clk);
    rdEn = 1'b1; address = PORT;
    #2 rstN = 1'b0;
    #1;
    checkOutput("async_filtered", filtered, 8'h00);
    checkOutput("async_flag", changeFlag, 1'b0);
    checkOutput("async_oe", dataOe, 1'b1);
    checkOutput("async_data", dataOut, 8'h00);
    modelReset();
    @(posedge clk);
    #2 rstN = 1'b1; rdEn = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(8'hAA, 7'h00, 1'b0, 1'b0, 1'b0);
      checkOutput("post_reset_latency", filtered, (i == 6) ? 8'hAA : 8'h00);
    end

    for (int n = 0; n < 120; n++) begin
      rPin = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
      hold = $urandom_range(1, 7);
      for (int k = 0; k < hold; k++) begin
        rRd   = ($urandom_range(0, 3) == 0);
        rAddr = ($urandom_range(0, 1) == 0) ? PORT : 7'h07;
        applyStimulus(rPin, rAddr, rRd, ($urandom_range(0, 4) == 0), 1'($urandom));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
